// File: rtl/regfile_context_sequencer_if.sv
// Handshake and register-bank bundle of the context sequencer.
// master: sequencer side; slave: bank, stream and command side.
interface regfile_context_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_save;
  logic [1:0]  cmd_file;
  logic [4:0]  cmd_first;
  logic [5:0]  cmd_count;
  logic [1:0]  rf_file_sel;
  logic [4:0]  rf_addr;
  logic        rf_rw;
  logic [31:0] rf_d_in;
  logic [31:0] rf_out_a;
  logic        so_valid;
  logic        so_ready;
  logic [31:0] so_data;
  logic        so_last;
  logic        si_valid;
  logic        si_ready;
  logic [31:0] si_data;
  logic        busy;
  logic        done;

  modport master (
    input  cmd_valid, cmd_save, cmd_file,
    input  cmd_first, cmd_count, rf_out_a,
    input  so_ready, si_valid, si_data,
    output cmd_ready, rf_file_sel, rf_addr,
    output rf_rw, rf_d_in, so_valid,
    output so_data, so_last, si_ready,
    output busy, done
  );

  modport slave (
    output cmd_valid, cmd_save, cmd_file,
    output cmd_first, cmd_count, rf_out_a,
    output so_ready, si_valid, si_data,
    input  cmd_ready, rf_file_sel, rf_addr,
    input  rf_rw, rf_d_in, so_valid,
    input  so_data, so_last, si_ready,
    input  busy, done
  );
endinterface

// File: rtl/regfile_context_sequencer.sv
// Register-bank context save/restore sequencer.
// Ports: clk, rst (async high), io (master: cmd, rf, so, si, busy/done).
module regfile_context_sequencer #(
  parameter int READ_LAT = 1
) (
  input logic                         clk,
  input logic                         rst,
  regfile_context_sequencer_if.master io
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    SO_HOLD,
    WR_ACCEPT,
    WR_COMMIT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [1:0]  file_q;
  logic [4:0]  addr_q;
  logic [5:0]  remaining;
  logic [1:0]  lat_cnt;
  logic [31:0] so_data_q;
  logic [31:0] d_in_q;
  logic        rw_q;
  logic        accept;
  logic        so_hs;
  logic        si_hs;
  logic        last_word;
  logic        lat_hit;

  assign accept    = io.cmd_valid && (state == IDLE);
  assign so_hs     = io.so_ready && (state == SO_HOLD);
  assign si_hs     = io.si_valid && (state == WR_ACCEPT);
  assign last_word = (remaining == 6'd1);
  assign lat_hit   = (lat_cnt == 2'(READ_LAT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (accept)
          state_d = io.cmd_save ? RD_WAIT : WR_ACCEPT;
      RD_WAIT:
        if (lat_hit) state_d = SO_HOLD;
      SO_HOLD:
        if (io.so_ready)
          state_d = last_word ? DONE : RD_WAIT;
      WR_ACCEPT:
        if (io.si_valid) state_d = WR_COMMIT;
      WR_COMMIT:
        state_d = last_word ? DONE : WR_ACCEPT;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // rf_rw follows the next state so the write strobe
  // comes straight off a flop during WR_COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      file_q    <= '0;
      addr_q    <= '0;
      remaining <= '0;
      lat_cnt   <= '0;
      so_data_q <= '0;
      d_in_q    <= '0;
      rw_q      <= 1'b1;
    end else begin
      rw_q <= (state_d != WR_COMMIT);
      if (accept) begin
        file_q    <= io.cmd_file;
        addr_q    <= io.cmd_first;
        remaining <= (io.cmd_count == 6'd0) ?
                     6'd32 : io.cmd_count;
        lat_cnt   <= '0;
      end
      if (state == RD_WAIT) begin
        if (lat_hit) begin
          so_data_q <= io.rf_out_a;
          lat_cnt   <= '0;
        end else begin
          lat_cnt <= lat_cnt + 2'd1;
        end
      end
      if (so_hs || (state == WR_COMMIT)) begin
        remaining <= remaining - 6'd1;
        addr_q    <= addr_q + 5'd1;
      end
      if (si_hs) d_in_q <= io.si_data;
    end
  end

  assign io.cmd_ready   = (state == IDLE);
  assign io.busy        = (state != IDLE);
  assign io.done        = (state == DONE);
  assign io.so_valid    = (state == SO_HOLD);
  assign io.so_last     = (state == SO_HOLD) && last_word;
  assign io.si_ready    = (state == WR_ACCEPT);
  assign io.so_data     = so_data_q;
  assign io.rf_d_in     = d_in_q;
  assign io.rf_rw       = rw_q;
  assign io.rf_addr     = addr_q;
  assign io.rf_file_sel = file_q;

endmodule
